// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ==================================================================
// arb_pkg : shared types for the fetch/data memory arbiter
// Rev 1.0
// ==================================================================
package arb_pkg;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_priority.sv
`default_nettype none
// ==================================================================
// arb_priority : data-first winner select with fetch starvation guard
// Rev 1.0
// ==================================================================
module arb_priority
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic       arb_en_i,
    output arb_owner_e winner_o
);

    localparam int               CNT_W   = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam bit               PRIO_EN = (STARVE_MAX > 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fetch_prio;

    assign fetch_prio = PRIO_EN && (cnt_q == CNT_MAX);
    assign winner_o   = (if_req_i && (!dm_req_i || fetch_prio)) ? OWN_IF : OWN_DM;

    // Counts arbitrations fetch lost while asking; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (arb_en_i && if_req_i) begin
            if (winner_o == OWN_IF) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ==================================================================
// imem_dmem_arbiter : shares one single-port memory between fetch and MEM
// Rev 1.0
// ==================================================================
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          pc_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0] lat_q, lat_d;
    logic                 flush_q, flush_d;

    logic       any_req;
    logic       arb_en;
    arb_owner_e winner;

    assign any_req = if_req | dm_req;
    assign arb_en  = any_req & ((state_q == IDLE) | (state_q == RESP));

    arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_priority (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .arb_en_i (arb_en),
        .winner_o (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;
        flush_d = flush_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = ISSUE;
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                lat_d = lat_q - LAT_CNT_W'(1);
                if (lat_q == LAT_CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                state_d = any_req ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new transaction latches the winner; otherwise a flush may mark an owned fetch.
        if (arb_en) begin
            owner_d = winner;
            we_d    = (winner == OWN_DM) & dm_we;
            addr_d  = (winner == OWN_DM) ? dm_addr : if_addr;
            if (winner == OWN_DM) wdata_d = dm_wdata;
            flush_d = 1'b0;
        end else if (((state_q == ISSUE) || (state_q == WAIT)) && (owner_q == OWN_IF) && if_flush) begin
            flush_d = 1'b1;
        end
    end

    always_comb begin
        mem_en    = (state_q == ISSUE);
        mem_read  = mem_en & ~we_q;
        mem_write = mem_en & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_gnt    = mem_en & (owner_q == OWN_IF);
        dm_gnt    = mem_en & (owner_q == OWN_DM);
        if_rvalid = (state_q == RESP) & (owner_q == OWN_IF) & ~flush_q & ~if_flush;
        dm_rvalid = (state_q == RESP) & (owner_q == OWN_DM);
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        pc_stall  = if_req & ~if_rvalid;
        dm_stall  = dm_req | ((owner_q == OWN_DM) & (state_q != IDLE) & ~dm_rvalid);
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// Drives two arbiters (MEM_LAT 1 and 3) with directed and random traffic
// and compares every cycle against a transaction-level model.
module tb_imem_dmem_arbiter;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req [2];
    logic [31:0] if_addr [2];
    logic        if_flush [2];
    logic        dm_req [2];
    logic        dm_we [2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_wdata [2];
    logic        if_gnt [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata [2];
    logic        pc_stall [2];
    logic        dm_gnt [2];
    logic        dm_rvalid [2];
    logic [31:0] dm_rdata [2];
    logic        dm_stall [2];
    logic        mem_en [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        imem_dmem_arbiter #(
            .AW(32), .DW(32), .MEM_LAT((k == 0) ? 1 : 3), .STARVE_MAX(SM)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[k]), .if_addr(if_addr[k]), .if_flush(if_flush[k]),
            .if_gnt(if_gnt[k]), .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
            .pc_stall(pc_stall[k]),
            .dm_req(dm_req[k]), .dm_we(dm_we[k]), .dm_addr(dm_addr[k]), .dm_wdata(dm_wdata[k]),
            .dm_gnt(dm_gnt[k]), .dm_rvalid(dm_rvalid[k]), .dm_rdata(dm_rdata[k]),
            .dm_stall(dm_stall[k]),
            .mem_en(mem_en[k]), .mem_read(mem_read[k]), .mem_write(mem_write[k]),
            .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k])
        );
        assign mem_rdata[k] = mem_fn(mem_addr[k]);
    end

    int checks = 0;
    int errors = 0;

    // Model: a transaction is "busy" from its issue cycle (age 0) until age == MEM_LAT.
    bit          m_busy [2];
    int          m_age [2];
    bit          m_own [2];
    bit          m_sup [2];
    int          m_starve [2];
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];

    task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_age[k] = 0; m_own[k] = 0; m_sup[k] = 0;
            m_starve[k] = 0; m_we[k] = 0; m_addr[k] = '0; m_wdata[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!m_busy[k] || m_age[k] == lat_of(k)) begin
                if (if_req[k] || dm_req[k]) begin
                    bit win_if;
                    win_if = if_req[k] && (!dm_req[k] || (SM > 0 && m_starve[k] >= SM));
                    if (win_if) m_starve[k] = 0;
                    else if (if_req[k] && m_starve[k] < SM) m_starve[k]++;
                    m_busy[k] = 1; m_age[k] = 0; m_sup[k] = 0;
                    m_own[k]  = !win_if;
                    m_addr[k] = win_if ? if_addr[k] : dm_addr[k];
                    m_we[k]   = !win_if && dm_we[k];
                    if (!win_if) m_wdata[k] = dm_wdata[k];
                end else begin
                    m_busy[k] = 0;
                end
            end else begin
                if (!m_own[k] && if_flush[k]) m_sup[k] = 1;
                m_age[k]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic iss, resp, e_irv, e_drv;
            iss   = m_busy[k] && m_age[k] == 0;
            resp  = m_busy[k] && m_age[k] == lat_of(k);
            e_irv = resp && !m_own[k] && !m_sup[k] && !if_flush[k];
            e_drv = resp && m_own[k];
            chk1("if_gnt", k, if_gnt[k], iss && !m_own[k]);
            chk1("dm_gnt", k, dm_gnt[k], iss && m_own[k]);
            chk1("mem_en", k, mem_en[k], iss);
            chk1("mem_read", k, mem_read[k], iss && !m_we[k]);
            chk1("mem_write", k, mem_write[k], iss && m_we[k]);
            chk1("if_rvalid", k, if_rvalid[k], e_irv);
            chk1("dm_rvalid", k, dm_rvalid[k], e_drv);
            chk1("pc_stall", k, pc_stall[k], if_req[k] && !e_irv);
            chk1("dm_stall", k, dm_stall[k], dm_req[k] || (m_busy[k] && m_own[k] && !e_drv));
            chk32("mem_addr", k, mem_addr[k], m_addr[k]);
            if (iss && m_we[k]) chk32("mem_wdata", k, mem_wdata[k], m_wdata[k]);
            if (e_irv) chk32("if_rdata", k, if_rdata[k], mem_fn(m_addr[k]));
            if (e_drv && !m_we[k]) chk32("dm_rdata", k, dm_rdata[k], mem_fn(m_addr[k]));
        end
    endtask

    // Requesters hold until granted; in random mode they also raise new traffic.
    task automatic auto_req(input bit rnd);
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k] && m_age[k] == 0 && !m_own[k]) if_req[k] = 1'b0;
            if (m_busy[k] && m_age[k] == 0 && m_own[k]) dm_req[k] = 1'b0;
            if (rnd) begin
                if (!if_req[k] && $urandom_range(0, 2) == 0) begin
                    if_req[k] = 1'b1; if_addr[k] = $urandom & 32'hFFFF_FFFC;
                end
                if (!dm_req[k] && $urandom_range(0, 2) == 0) begin
                    dm_req[k] = 1'b1; dm_we[k] = 1'($urandom_range(0, 1));
                    dm_addr[k] = $urandom; dm_wdata[k] = $urandom;
                end
                if_flush[k] = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic do_cycle(input bit rnd);
        model_step();
        @(posedge clk);
        #1;
        check_all();
        auto_req(rnd);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk1({tag, "_mem_en"}, k, mem_en[k], 1'b0);
            chk1({tag, "_mem_rd"}, k, mem_read[k], 1'b0);
            chk1({tag, "_mem_wr"}, k, mem_write[k], 1'b0);
            chk1({tag, "_if_gnt"}, k, if_gnt[k], 1'b0);
            chk1({tag, "_dm_gnt"}, k, dm_gnt[k], 1'b0);
            chk1({tag, "_if_rv"}, k, if_rvalid[k], 1'b0);
            chk1({tag, "_dm_rv"}, k, dm_rvalid[k], 1'b0);
            chk32({tag, "_addr"}, k, mem_addr[k], 32'h0);
            chk32({tag, "_wdata"}, k, mem_wdata[k], 32'h0);
        end
    endtask

    task automatic drop_all();
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_flush[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
        end
    endtask

    initial begin
        bit          got_if [2];
        int          ndm [2];
        int          nrv [2];
        int          nwr [2];
        int          wr_c [2];
        int          rv_c [2];
        logic [31:0] wd [2];

        for (int k = 0; k < 2; k++) begin
            if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        drop_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(0);

        // Lone fetch from IDLE
        for (int k = 0; k < 2; k++) begin if_req[k] = 1'b1; if_addr[k] = 32'h10; end
        #1;
        chk1("t1_pc_stall0", 0, pc_stall[0], 1'b1);
        do_cycle(0);
        chk1("t1_if_gnt", 0, if_gnt[0], 1'b1);
        chk1("t1_mem_en", 0, mem_en[0], 1'b1);
        chk32("t1_mem_addr", 0, mem_addr[0], 32'h10);
        do_cycle(0);
        chk1("t1_if_rvalid", 0, if_rvalid[0], 1'b1);
        chk32("t1_if_rdata", 0, if_rdata[0], mem_fn(32'h10));
        repeat (4) do_cycle(0);

        // Simultaneous fetch and load: data first, fetch back-to-back
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b1; if_addr[k] = 32'h20;
            dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 32'h200;
        end
        do_cycle(0);
        chk1("t2_dm_gnt", 0, dm_gnt[0], 1'b1);
        chk1("t2_if_gnt", 0, if_gnt[0], 1'b0);
        do_cycle(0);
        chk1("t2_dm_rvalid", 0, dm_rvalid[0], 1'b1);
        chk32("t2_dm_rdata", 0, dm_rdata[0], mem_fn(32'h200));
        do_cycle(0);
        chk1("t2_if_gnt_b2b", 0, if_gnt[0], 1'b1);
        do_cycle(0);
        chk1("t2_if_rvalid", 0, if_rvalid[0], 1'b1);
        repeat (8) do_cycle(0);

        // Starvation: continuous loads against a held fetch
        for (int k = 0; k < 2; k++) begin
            got_if[k] = 0; ndm[k] = 0; if_req[k] = 1'b1; if_addr[k] = 32'h300;
        end
        for (int c = 0; c < 80 && !(got_if[0] && got_if[1]); c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!got_if[k] && !dm_req[k]) begin
                    dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 32'h400 + 32'(c * 4);
                end
            end
            do_cycle(0);
            for (int k = 0; k < 2; k++) begin
                if (!got_if[k]) begin
                    if (dm_gnt[k]) ndm[k]++;
                    if (if_gnt[k]) got_if[k] = 1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk1("t3_if_granted", k, got_if[k], 1'b1);
            chk32("t3_dm_grants", k, 32'(ndm[k]), 32'd4);
        end
        repeat (10) do_cycle(0);

        // Store
        for (int k = 0; k < 2; k++) begin
            dm_req[k] = 1'b1; dm_we[k] = 1'b1; dm_addr[k] = 32'h40; dm_wdata[k] = 32'hDEADBEEF;
            nwr[k] = 0; wr_c[k] = -100; rv_c[k] = -1; wd[k] = '0;
        end
        for (int c = 0; c < 10; c++) begin
            do_cycle(0);
            for (int k = 0; k < 2; k++) begin
                if (mem_write[k]) begin nwr[k]++; wr_c[k] = c; wd[k] = mem_wdata[k]; end
                if (dm_rvalid[k] && rv_c[k] < 0) rv_c[k] = c;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk32("t4_write_count", k, 32'(nwr[k]), 32'd1);
            chk32("t4_wdata", k, wd[k], 32'hDEADBEEF);
            chk32("t4_ack_delay", k, 32'(rv_c[k] - wr_c[k]), 32'(lat_of(k)));
            dm_we[k] = 1'b0;
        end

        // Flush during WAIT of a fetch (slow instance), then a normal fetch
        for (int k = 0; k < 2; k++) begin if_req[k] = 1'b1; if_addr[k] = 32'h80; nrv[k] = 0; end
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 2; k++) if_flush[k] = (c == 2);
            do_cycle(0);
            for (int k = 0; k < 2; k++) if (if_rvalid[k]) nrv[k]++;
        end
        chk32("t5_flushed_rvalids", 1, 32'(nrv[1]), 32'd0);
        chk32("t5_unflushed_rvalids", 0, 32'(nrv[0]), 32'd1);
        for (int k = 0; k < 2; k++) begin if_req[k] = 1'b1; if_addr[k] = 32'h84; nrv[k] = 0; end
        for (int c = 0; c < 8; c++) begin
            do_cycle(0);
            for (int k = 0; k < 2; k++) if (if_rvalid[k]) nrv[k]++;
        end
        for (int k = 0; k < 2; k++) chk32("t5_next_fetch", k, 32'(nrv[k]), 32'd1);

        // Asynchronous reset in the middle of a transaction
        for (int k = 0; k < 2; k++) begin if_req[k] = 1'b1; if_addr[k] = 32'h90; end
        do_cycle(0);
        do_cycle(0);
        rst_n = 1'b0;
        drop_all();
        #1;
        chk_zero("t6");
        for (int k = 0; k < 2; k++) begin
            chk1("t6_pc_stall", k, pc_stall[k], 1'b0);
            chk1("t6_dm_stall", k, dm_stall[k], 1'b0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) nrv[k] = 0;
        for (int c = 0; c < 5; c++) begin
            do_cycle(0);
            for (int k = 0; k < 2; k++) if (if_rvalid[k] || dm_rvalid[k]) nrv[k]++;
        end
        for (int k = 0; k < 2; k++) chk32("t6_no_rvalid", k, 32'(nrv[k]), 32'd0);
        for (int k = 0; k < 2; k++) begin if_req[k] = 1'b1; if_addr[k] = 32'hA0; end
        do_cycle(0);
        for (int k = 0; k < 2; k++) chk1("t6_new_gnt", k, if_gnt[k], 1'b1);
        repeat (6) do_cycle(0);

        // Random traffic
        for (int c = 0; c < 600; c++) do_cycle(1);
        for (int k = 0; k < 2; k++) if_flush[k] = 1'b0;
        repeat (20) do_cycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
